mips32_fetch_queue: RTL

//  Instruction fetch front-end with prefetch buffering for the pipelined MIPS32 core.
//  - Sits directly upstream of the ID stage.
//  - Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
//  - Buffers returned instructions with their NPC in a small FIFO.
//  - Presents the FIFO head to ID under valid/ready.
//  - Handles branch redirects (flush) and halt.

---
 rtl/mips32_fetch_queue_pkg.sv | 29 ++
 rtl/mips32_fetch_queue_if.sv | 30 +++
 rtl/mips32_fetch_queue_fifo.sv | 50 +++++
 rtl/mips32_fetch_queue.sv | 114 +++++++++++
 4 files changed

// File: rtl/mips32_fetch_queue_pkg.sv
// Shared MIPS32 definitions: opcodes, word width and fetch FSM state encoding.
package mips32_pkg;

    localparam int unsigned WORD_W = 32;

    // Opcode field values, instruction bits [31:26]
    localparam logic [5:0] ADD   = 6'b000000;
    localparam logic [5:0] SUB   = 6'b000001;
    localparam logic [5:0] AND   = 6'b000010;
    localparam logic [5:0] OR    = 6'b000011;
    localparam logic [5:0] SLT   = 6'b000100;
    localparam logic [5:0] MUL   = 6'b000101;
    localparam logic [5:0] LW    = 6'b001000;
    localparam logic [5:0] SW    = 6'b001001;
    localparam logic [5:0] ADDI  = 6'b001010;
    localparam logic [5:0] SUBI  = 6'b001011;
    localparam logic [5:0] SLTI  = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ  = 6'b001110;
    localparam logic [5:0] HLT   = 6'b111111;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port and the IF->ID valid/ready port.
// master = fetch unit, slave = memory / ID stage side.
interface mips32_fetch_queue_if
    import mips32_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;
    logic              id_ready;
    logic              if_valid;
    logic [WORD_W-1:0] if_ir;
    logic [WORD_W-1:0] if_npc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  id_ready,
        output if_valid, if_ir, if_npc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output id_ready,
        input  if_valid, if_ir, if_npc
    );
endinterface

// File: rtl/mips32_fetch_queue_fifo.sv
// Prefetch FIFO: DEPTH entries of {npc, ir}, synchronous flush, occupancy count,
// head word forced to zero when empty so no stale/X data reaches ID.
module mips32_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointer and occupancy bookkeeping; flush overrides push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a non-empty head
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction fetch front-end: owns the fetch PC, issues one imem read at a
// time with a FIFO slot reserved at issue, buffers {pc+1, word} and hands the head to ID.
// Redirects flush the queue; halt stops fetching once any outstanding read completes.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    mips32_fetch_queue_if.master   bus,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    input  logic                   halt,
    output logic                   taken_branch,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   halted
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] req_addr;
    logic              halt_seen;
    logic              halting;
    logic              redirect_take;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2*WORD_W-1:0] head;

    // halt beats a same-cycle redirect and blocks all later ones
    assign halting       = halt || halt_seen;
    assign redirect_take = redirect_valid && !halting;

    // Address is latched at issue so a redirect during DISCARD cannot disturb it
    assign bus.imem_req  = (state == WAIT) || (state == DISCARD);
    assign bus.imem_addr = req_addr;
    assign bus.if_valid  = (fifo_count != '0) && !redirect_take;
    assign bus.if_npc    = head[2*WORD_W-1:WORD_W];
    assign bus.if_ir     = head[WORD_W-1:0];
    assign pop           = bus.if_valid && bus.id_ready;
    assign halted        = (state == HALT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Next-state, issue and push decisions
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            FETCH: begin
                if (halting) begin
                    state_nxt = HALT;
                end else if (!redirect_take && (fifo_count < CW'(DEPTH))) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_ack) begin
                    push      = !redirect_take;
                    state_nxt = halting ? HALT : FETCH;
                end else if (redirect_take) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.imem_ack) state_nxt = halting ? HALT : FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // PC, request address, sticky halt and branch-taken pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            req_addr     <= '0;
            halt_seen    <= 1'b0;
            taken_branch <= 1'b0;
        end else begin
            taken_branch <= redirect_take;
            if (halt)  halt_seen <= 1'b1;
            if (issue) req_addr  <= pc[ADDR_W-1:0];
            if (redirect_take)  pc <= redirect_pc;
            else if (push)      pc <= pc + 32'd1;
        end
    end

    mips32_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_take),
        .din   ({pc + 32'd1, bus.imem_rdata}),
        .head  (head),
        .count (fifo_count)
    );

endmodule
